forwarding_scoreboard: RTL and testbench

Parametrised hazard/forwarding unit for the ARM-style five-stage pipeline. It tracks destination tags of in-flight instructions past ID (EX, MEM, WB by default) in an internal tag shift-register. It selects per-source-operand bypass data for the ID-stage PA/PB/PD muxes and raises a load-use stall. It replaces the fixed three-operand, three-stage operand muxes with a block generalised in operand count, pipeline depth, load latency and register-address width, and adds stall accounting.

---
 rtl/forwarding_scoreboard.sv | 113 +++++++++++
 tb/tb_forwarding_scoreboard.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : forwarding_scoreboard
// Brief    : Tag-tracking operand bypass selector with load-use stall detect.
// Revision : 1.0
// ============================================================================
module forwarding_scoreboard #(
    parameter int NUM_SRC          = 3,
    parameter int DEPTH            = 3,
    parameter int DATA_W           = 32,
    parameter int REG_ADDR_W       = 4,
    parameter int LOAD_READY_STAGE = 1,
    parameter int NO_FWD_REG       = 15,
    parameter int SEL_W            = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_id_valid,
    input  logic                          i_id_rf_e,
    input  logic                          i_id_load,
    input  logic [REG_ADDR_W-1:0]         i_id_rd,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] i_id_src,
    input  logic [NUM_SRC-1:0]            i_id_src_used,
    input  logic [NUM_SRC*DATA_W-1:0]     i_rf_data,
    input  logic [DEPTH*DATA_W-1:0]       i_stage_data,
    input  logic                          i_flush,
    output logic [NUM_SRC*DATA_W-1:0]     o_fwd_data,
    output logic [NUM_SRC*SEL_W-1:0]      o_fwd_sel,
    output logic                          o_stall,
    output logic [15:0]                   o_stall_count
);

    logic [DEPTH-1:0]            r_vld;
    logic [DEPTH-1:0]            r_rfe;
    logic [DEPTH-1:0]            r_load;
    logic [DEPTH*REG_ADDR_W-1:0] r_rd;
    logic [15:0]                 r_stall_cnt;
    logic [NUM_SRC-1:0]          w_hazard;
    logic                        w_stall;
    logic                        w_push;

    assign w_stall = i_id_valid & ~i_flush & (|w_hazard);
    assign w_push  = i_id_valid & ~w_stall & ~i_flush;

    // Tag pipeline: a stalled or flushed ID slot enters EX as a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld  <= '0;
            r_rfe  <= '0;
            r_load <= '0;
            r_rd   <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_vld[k]  <= r_vld[k-1];
                r_rfe[k]  <= r_rfe[k-1];
                r_load[k] <= r_load[k-1];
                r_rd[k*REG_ADDR_W +: REG_ADDR_W] <= r_rd[(k-1)*REG_ADDR_W +: REG_ADDR_W];
            end
            r_vld[0]                <= w_push;
            r_rfe[0]                <= i_id_rf_e;
            r_load[0]               <= i_id_load;
            r_rd[0 +: REG_ADDR_W]   <= i_id_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [REG_ADDR_W-1:0] w_src;
        logic                  w_hit;
        logic                  w_haz;
        logic [SEL_W-1:0]      w_sel;
        logic [DATA_W-1:0]     w_data;

        assign w_src = i_id_src[gi*REG_ADDR_W +: REG_ADDR_W];

        // Scan youngest-first; the first hit decides, older hits are shadowed.
        always_comb begin
            w_hit  = 1'b0;
            w_haz  = 1'b0;
            w_sel  = '0;
            w_data = i_rf_data[gi*DATA_W +: DATA_W];
            for (int k = 0; k < DEPTH; k++) begin
                if (!w_hit && r_vld[k] && r_rfe[k] && i_id_src_used[gi] &&
                    (r_rd[k*REG_ADDR_W +: REG_ADDR_W] == w_src) &&
                    (w_src != REG_ADDR_W'(NO_FWD_REG))) begin
                    w_hit = 1'b1;
                    if (r_load[k] && (k < LOAD_READY_STAGE)) begin
                        w_haz = 1'b1;
                    end else begin
                        w_sel  = SEL_W'(k + 1);
                        w_data = i_stage_data[k*DATA_W +: DATA_W];
                    end
                end
            end
        end

        assign w_hazard[gi]                    = w_haz;
        assign o_fwd_sel[gi*SEL_W +: SEL_W]    = w_sel;
        assign o_fwd_data[gi*DATA_W +: DATA_W] = w_data;
    end

    assign o_stall       = w_stall;
    assign o_stall_count = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_forwarding_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_forwarding_scoreboard
// Brief    : Directed scoreboard bench for forwarding_scoreboard.
// Revision : 1.0
// ============================================================================
module tb_forwarding_scoreboard;

    localparam int SW  = 2;
    localparam int SSW = 5;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        id_valid, id_rf_e, id_load, flush;
    logic [3:0]  id_rd;
    logic [11:0] id_src;
    logic [2:0]  id_used;
    logic [95:0] rf_data, stage_data;
    logic [95:0] fwd_data;
    logic [5:0]  fwd_sel;
    logic        stall;
    logic [15:0] stall_count;

    logic         s_reset;
    logic [95:0]  s_fwd_data;
    logic [14:0]  s_fwd_sel;
    logic         s_stall;
    logic [15:0]  s_cnt;
    logic [511:0] s_stage_data;
    logic [11:0]  s_src;

    forwarding_scoreboard u_dut (
        .clk(clk), .reset(reset),
        .i_id_valid(id_valid), .i_id_rf_e(id_rf_e), .i_id_load(id_load),
        .i_id_rd(id_rd), .i_id_src(id_src), .i_id_src_used(id_used),
        .i_rf_data(rf_data), .i_stage_data(stage_data), .i_flush(flush),
        .o_fwd_data(fwd_data), .o_fwd_sel(fwd_sel),
        .o_stall(stall), .o_stall_count(stall_count)
    );

    // Deep instance where loads never become forwardable: near-continuous stall.
    forwarding_scoreboard #(.DEPTH(16), .LOAD_READY_STAGE(16)) u_sat (
        .clk(clk), .reset(s_reset),
        .i_id_valid(1'b1), .i_id_rf_e(1'b1), .i_id_load(1'b1),
        .i_id_rd(4'd5), .i_id_src(s_src), .i_id_src_used(3'b001),
        .i_rf_data(rf_data), .i_stage_data(s_stage_data), .i_flush(1'b0),
        .o_fwd_data(s_fwd_data), .o_fwd_sel(s_fwd_sel),
        .o_stall(s_stall), .o_stall_count(s_cnt)
    );

    string       q_name[$];
    int          q_kind[$];
    int          q_idx[$];
    logic [31:0] q_exp[$];
    int          n_vec = 0;
    int          n_err = 0;
    event        ev_sample;

    localparam int K_SEL = 0, K_DATA = 1, K_STALL = 2, K_CNT = 3, K_SCNT = 4, K_SSTALL = 5;

    task automatic expect_push(input string n, input int kind, input int idx, input logic [31:0] v);
        q_name.push_back(n);
        q_kind.push_back(kind);
        q_idx.push_back(idx);
        q_exp.push_back(v);
    endtask

    task automatic sample();
        #2;
        -> ev_sample;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic rfe, input logic ld, input logic [3:0] rd,
                         input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [2:0] used, input logic fl);
        id_valid = v;
        id_rf_e  = rfe;
        id_load  = ld;
        id_rd    = rd;
        id_src   = {s2, s1, s0};
        id_used  = used;
        flush    = fl;
    endtask

    always begin
        @(ev_sample);
        while (q_kind.size() > 0) begin
            string       n;
            int          kd, ix;
            logic [31:0] e, a;
            n  = q_name.pop_front();
            kd = q_kind.pop_front();
            ix = q_idx.pop_front();
            e  = q_exp.pop_front();
            case (kd)
                K_SEL:    a = 32'(fwd_sel[ix*SW +: SW]);
                K_DATA:   a = fwd_data[ix*32 +: 32];
                K_STALL:  a = {31'b0, stall};
                K_CNT:    a = {16'b0, stall_count};
                K_SCNT:   a = {16'b0, s_cnt};
                K_SSTALL: a = {31'b0, s_stall};
                default:  a = 'x;
            endcase
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", n, a, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        s_reset      = 1'b1;
        s_src        = {4'd0, 4'd0, 4'd5};
        s_stage_data = '0;
        rf_data      = {32'h0000F002, 32'h0000F001, 32'h0000F000};
        stage_data   = {32'h0000000C, 32'h0000000B, 32'h00000011};
        issue(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        expect_push("reset_stall", K_STALL, 0, 32'd0);
        expect_push("reset_cnt",   K_CNT,   0, 32'd0);
        expect_push("reset_sel0",  K_SEL,   0, 32'd0);
        expect_push("reset_data0", K_DATA,  0, 32'h0000F000);
        sample();
        step();

        // ADD r1, then read r1 from EX
        issue(1, 1, 0, 4'd1, 0, 0, 0, 3'b000, 0); step();
        issue(1, 0, 0, 4'd0, 4'd1, 0, 0, 3'b001, 0);
        expect_push("ex_sel0",  K_SEL,   0, 32'd1);
        expect_push("ex_data0", K_DATA,  0, 32'h11);
        expect_push("ex_stall", K_STALL, 0, 32'd0);
        sample(); step();

        // two writers of r3, youngest wins
        issue(1, 1, 0, 4'd3, 0, 0, 0, 3'b000, 0); step();
        issue(1, 1, 0, 4'd3, 0, 0, 0, 3'b000, 0); step();
        stage_data = {32'h0000000C, 32'h0000000B, 32'h0000000A};
        issue(1, 0, 0, 4'd0, 4'd3, 0, 0, 3'b001, 0);
        expect_push("prio_sel0",  K_SEL,  0, 32'd1);
        expect_push("prio_data0", K_DATA, 0, 32'hA);
        sample(); step();

        issue(1, 1, 0, 4'd6, 4'd3, 0, 4'd3, 3'b101, 0);
        expect_push("mem_sel0",  K_SEL,  0, 32'd2);
        expect_push("mem_data0", K_DATA, 0, 32'hB);
        expect_push("mem_sel2",  K_SEL,  2, 32'd2);
        sample(); step();

        // three operands resolved independently: EX, WB, none
        issue(1, 0, 0, 4'd0, 4'd6, 4'd3, 4'd7, 3'b111, 0);
        expect_push("multi_sel0",  K_SEL,   0, 32'd1);
        expect_push("multi_data0", K_DATA,  0, 32'hA);
        expect_push("multi_sel1",  K_SEL,   1, 32'd3);
        expect_push("multi_data1", K_DATA,  1, 32'hC);
        expect_push("multi_sel2",  K_SEL,   2, 32'd0);
        expect_push("multi_data2", K_DATA,  2, 32'h0000F002);
        expect_push("multi_stall", K_STALL, 0, 32'd0);
        sample(); step();

        // LDR r5 then load-use on operand 1
        issue(1, 1, 1, 4'd5, 0, 0, 0, 3'b000, 0); step();
        issue(1, 0, 0, 4'd0, 0, 4'd5, 0, 3'b010, 0);
        expect_push("lu_stall", K_STALL, 0, 32'd1);
        expect_push("lu_sel1",  K_SEL,   1, 32'd0);
        expect_push("lu_data1", K_DATA,  1, 32'h0000F001);
        expect_push("lu_cnt0",  K_CNT,   0, 32'd0);
        sample();
        n_vec++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL lu_stall_direct: got %b expected 1", stall);
        end
        step();
        expect_push("lu2_stall", K_STALL, 0, 32'd0);
        expect_push("lu2_sel1",  K_SEL,   1, 32'd2);
        expect_push("lu2_data1", K_DATA,  1, 32'hB);
        expect_push("lu2_cnt",   K_CNT,   0, 32'd1);
        sample();
        n_vec++;
        if (fwd_data[63:32] !== stage_data[63:32]) begin
            n_err++;
            $display("FAIL lu2_data1_direct: got %h expected %h", fwd_data[63:32], stage_data[63:32]);
        end
        step();

        // asynchronous reset in the middle of a stall
        issue(1, 1, 1, 4'd5, 0, 0, 0, 3'b000, 0); step();
        issue(1, 0, 0, 4'd0, 0, 4'd5, 0, 3'b010, 0);
        expect_push("pre_rst_stall", K_STALL, 0, 32'd1);
        expect_push("pre_rst_cnt",   K_CNT,   0, 32'd1);
        sample();
        reset = 1'b1;
        expect_push("rst_stall", K_STALL, 0, 32'd0);
        expect_push("rst_cnt",   K_CNT,   0, 32'd0);
        expect_push("rst_sel1",  K_SEL,   1, 32'd0);
        expect_push("rst_data1", K_DATA,  1, 32'h0000F001);
        sample();
        n_vec++;
        if ((stall !== 1'b0) || (stall_count !== 16'd0)) begin
            n_err++;
            $display("FAIL rst_direct: got %b/%h expected 0/0000", stall, stall_count);
        end
        step();
        reset = 1'b0;
        expect_push("post_rst_stall", K_STALL, 0, 32'd0);
        expect_push("post_rst_cnt",   K_CNT,   0, 32'd0);
        sample(); step();

        // flushed writer leaves a bubble
        issue(1, 1, 0, 4'd2, 0, 0, 0, 3'b000, 1); step();
        issue(1, 0, 0, 4'd0, 4'd2, 0, 0, 3'b001, 0);
        expect_push("flush_sel0",  K_SEL,  0, 32'd0);
        expect_push("flush_data0", K_DATA, 0, 32'h0000F000);
        sample(); step();

        // flush overrides load-use stall
        issue(1, 1, 1, 4'd5, 0, 0, 0, 3'b000, 0); step();
        issue(1, 0, 0, 4'd0, 0, 4'd5, 0, 3'b010, 1);
        expect_push("flush_lu_stall", K_STALL, 0, 32'd0);
        expect_push("flush_lu_cnt",   K_CNT,   0, 32'd0);
        sample();
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL flush_lu_direct: got %b expected 0", stall);
        end
        step();
        issue(1, 0, 0, 4'd0, 0, 4'd5, 0, 3'b010, 0);
        expect_push("after_flush_stall", K_STALL, 0, 32'd0);
        expect_push("after_flush_sel1",  K_SEL,   1, 32'd2);
        expect_push("after_flush_data1", K_DATA,  1, 32'hB);
        sample(); step();

        // r15 never forwarded
        issue(1, 1, 0, 4'd15, 0, 0, 0, 3'b000, 0); step();
        issue(1, 1, 0, 4'd9, 4'd15, 4'd15, 0, 3'b011, 0);
        expect_push("pc_sel0",  K_SEL,  0, 32'd0);
        expect_push("pc_data0", K_DATA, 0, 32'h0000F000);
        expect_push("pc_sel1",  K_SEL,  1, 32'd0);
        sample(); step();

        // unused operand ignored; used twin still forwards
        issue(1, 0, 0, 4'd0, 4'd9, 0, 4'd9, 3'b100, 0);
        expect_push("unused_sel0",  K_SEL,  0, 32'd0);
        expect_push("unused_data0", K_DATA, 0, 32'h0000F000);
        expect_push("used_sel2",    K_SEL,  2, 32'd1);
        expect_push("used_data2",   K_DATA, 2, 32'hA);
        sample(); step();

        // r9 walks MEM -> WB -> out of the pipeline
        issue(0, 0, 0, 4'd0, 4'd9, 0, 0, 3'b001, 0);
        expect_push("walk_mem_sel0", K_SEL,  0, 32'd2);
        expect_push("walk_mem_data", K_DATA, 0, 32'hB);
        expect_push("idle_stall",    K_STALL, 0, 32'd0);
        sample(); step();
        expect_push("walk_wb_sel0", K_SEL,  0, 32'd3);
        expect_push("walk_wb_data", K_DATA, 0, 32'hC);
        sample(); step();
        expect_push("walk_out_sel0", K_SEL,  0, 32'd0);
        expect_push("walk_out_data", K_DATA, 0, 32'h0000F000);
        sample(); step();

        // saturation: 16 stalls per 17 cycles on the deep instance
        s_reset = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        expect_push("sat_cnt_16",  K_SCNT,   0, 32'd16);
        expect_push("sat_nostall", K_SSTALL, 0, 32'd0);
        sample();
        repeat (69700 - 17) @(posedge clk);
        #1;
        expect_push("sat_cnt_max", K_SCNT, 0, 32'h0000FFFF);
        sample();
        n_vec++;
        if (s_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_cnt_direct: got %h expected ffff", s_cnt);
        end

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
